// File: rtl/vout_timing_gen_cfg.sv
// vout_timing_gen_cfg: video timing generator producing HS/VS/DE and frame/line strobes.
// Timing loads into a shadow copy and is applied only at a frame boundary.
// Ports:
//   dp_clk, rst_n        pixel clock, asynchronous active-low reset
//   run                  1 = generate timing, 0 = idle with counters at 0
//   cfg_load             1-cycle strobe capturing cfg_h_*/cfg_v_*/cfg_*_pol
//   cfg_pending, cfg_err config waiting for frame end / rejected load pulse
//   hs, vs, de           registered syncs (configured polarity) and active video
//   frame_start          1-cycle pulse at h=0,v=0
//   line_start           1-cycle pulse at every h=0
// Optional: define VTG_COORD_EN to add x_pos/y_pos (active-area coordinates, aligned with de).
module vout_timing_gen_cfg #(
   parameter int CW = 12
) (
   input  logic          dp_clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic          cfg_load,
   input  logic [CW-1:0] cfg_h_fp,
   input  logic [CW-1:0] cfg_h_sync,
   input  logic [CW-1:0] cfg_h_bp,
   input  logic [CW-1:0] cfg_h_active,
   input  logic [CW-1:0] cfg_v_fp,
   input  logic [CW-1:0] cfg_v_sync,
   input  logic [CW-1:0] cfg_v_bp,
   input  logic [CW-1:0] cfg_v_active,
   input  logic          cfg_hs_pol,
   input  logic          cfg_vs_pol,
   output logic          cfg_pending,
   output logic          cfg_err,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic          frame_start,
   output logic          line_start
`ifdef VTG_COORD_EN
   ,
   output logic [CW-1:0] x_pos,
   output logic [CW-1:0] y_pos
`endif
);
   localparam int SW = CW + 2;
   typedef struct packed {
      logic [CW-1:0] h_fp, h_sync, h_bp, h_act, v_fp, v_sync, v_bp, v_act;
      logic          hs_pol, vs_pol;
   } cfg_t;
   cfg_t cfg_in, shd_q, shd_d, app_q, app_d;
   logic [CW-1:0] h_q, h_d, v_q, v_d;
   logic [SW-1:0] in_h_tot, in_v_tot, h_ext, v_ext;
   logic [SW-1:0] hs_end, vs_end, h_start, v_start, h_tot, v_tot;
   logic val_q, val_d, act_q, pend_d, err_d;
   logic cfg_ok, load_ok, run_eff, h_wrap, v_wrap, at_end, direct, g;
   logic hs_d, vs_d, de_d, fs_d, ls_d;
`ifdef VTG_COORD_EN
   logic [CW-1:0] x_d, y_d;
`endif
   assign cfg_in = '{h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp, h_act: cfg_h_active,
                     v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp, v_act: cfg_v_active,
                     hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};
   always_comb begin
      in_h_tot = SW'(cfg_h_fp) + SW'(cfg_h_sync) + SW'(cfg_h_bp) + SW'(cfg_h_active);
      in_v_tot = SW'(cfg_v_fp) + SW'(cfg_v_sync) + SW'(cfg_v_bp) + SW'(cfg_v_active);
      cfg_ok   = (cfg_h_sync != '0) && (cfg_h_active != '0) && (cfg_v_sync != '0) && (cfg_v_active != '0)
              && (in_h_tot <= SW'((1 << CW) - 1)) && (in_v_tot <= SW'((1 << CW) - 1));
      hs_end   = SW'(app_q.h_fp) + SW'(app_q.h_sync);
      vs_end   = SW'(app_q.v_fp) + SW'(app_q.v_sync);
      h_start  = hs_end + SW'(app_q.h_bp);
      v_start  = vs_end + SW'(app_q.v_bp);
      h_tot    = h_start + SW'(app_q.h_act);
      v_tot    = v_start + SW'(app_q.v_act);
      h_ext    = SW'(h_q);
      v_ext    = SW'(v_q);
      run_eff  = run && val_q;
      h_wrap   = h_ext == h_tot - SW'(1);
      v_wrap   = v_ext == v_tot - SW'(1);
      at_end   = run_eff && h_wrap && v_wrap;
      load_ok  = cfg_load && cfg_ok;
      // a config may take effect now when idle, or at the last pixel of a frame if one is waiting
      direct   = !run_eff || (cfg_pending && at_end);
      shd_d    = load_ok ? cfg_in : shd_q;
      app_d    = (load_ok && direct) ? cfg_in : (cfg_pending && direct) ? shd_q : app_q;
      val_d    = val_q || (load_ok && direct);
      pend_d   = direct ? 1'b0 : (cfg_pending || load_ok);
      err_d    = cfg_load && !cfg_ok;
      h_d      = (!run_eff || h_wrap) ? '0 : h_q + CW'(1);
      v_d      = !run_eff ? '0 : h_wrap ? (v_wrap ? '0 : v_q + CW'(1)) : v_q;
      // decode stays enabled one extra cycle after run drops so the last counter state still reaches the outputs
      g        = run_eff || act_q;
      hs_d     = (g && h_ext >= SW'(app_q.h_fp) && h_ext < hs_end) ? app_q.hs_pol : !app_q.hs_pol;
      vs_d     = (g && v_ext >= SW'(app_q.v_fp) && v_ext < vs_end) ? app_q.vs_pol : !app_q.vs_pol;
      de_d     = g && h_ext >= h_start && v_ext >= v_start;
      fs_d     = g && h_q == '0 && v_q == '0;
      ls_d     = g && h_q == '0;
`ifdef VTG_COORD_EN
      x_d      = de_d ? CW'(h_ext - h_start) : '0;
      y_d      = de_d ? CW'(v_ext - v_start) : '0;
`endif
   end
   always_ff @(posedge dp_clk or negedge rst_n)
      if (!rst_n) begin
         shd_q       <= '0;
         app_q       <= '0;
         val_q       <= 1'b0;
         act_q       <= 1'b0;
         h_q         <= '0;
         v_q         <= '0;
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
         hs          <= 1'b0;
         vs          <= 1'b0;
         de          <= 1'b0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
`ifdef VTG_COORD_EN
         x_pos       <= '0;
         y_pos       <= '0;
`endif
      end else begin
         shd_q       <= shd_d;
         app_q       <= app_d;
         val_q       <= val_d;
         act_q       <= run_eff;
         h_q         <= h_d;
         v_q         <= v_d;
         cfg_pending <= pend_d;
         cfg_err     <= err_d;
         hs          <= hs_d;
         vs          <= vs_d;
         de          <= de_d;
         frame_start <= fs_d;
         line_start  <= ls_d;
`ifdef VTG_COORD_EN
         x_pos       <= x_d;
         y_pos       <= y_d;
`endif
      end
endmodule

// File: tb/tb_vout_timing_gen_cfg.sv
// tb_vout_timing_gen_cfg: table-driven, scoreboarded bench for vout_timing_gen_cfg
module tb_vout_timing_gen_cfg;
   localparam int CW = 12;
   logic dp_clk = 1'b0, rst_n = 1'b0, run = 1'b0, cfg_load = 1'b0;
   logic [CW-1:0] cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0, cfg_h_active = '0;
   logic [CW-1:0] cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0, cfg_v_active = '0;
   logic cfg_hs_pol = 1'b0, cfg_vs_pol = 1'b0;
   logic cfg_pending, cfg_err, hs, vs, de, frame_start, line_start;
`ifdef VTG_COORD_EN
   logic [CW-1:0] x_pos, y_pos;
`endif
   int n_tests = 0, n_fail = 0;
   typedef struct packed {
      int fr; int lines; int de_n; int first_de; int hs_off; int hs_w; int vs_n;
      logic hp; logic vp;
   } exp_t;
   typedef struct packed {
      int hfp; int hsy; int hbp; int hact; int vfp; int vsy; int vbp; int vact;
      logic hp; logic vp; logic err; logic pend;
      exp_t e;
   } vec_t;
   vec_t tab[9];
   exp_t sb[$];
   always #5 dp_clk = ~dp_clk;
   vout_timing_gen_cfg #(.CW(CW)) dut (
      .dp_clk(dp_clk), .rst_n(rst_n), .run(run), .cfg_load(cfg_load),
      .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_active(cfg_h_active),
      .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_active(cfg_v_active),
      .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
      .cfg_pending(cfg_pending), .cfg_err(cfg_err), .hs(hs), .vs(vs), .de(de),
      .frame_start(frame_start), .line_start(line_start)
`ifdef VTG_COORD_EN
      , .x_pos(x_pos), .y_pos(y_pos)
`endif
   );
   task automatic chk(input string n, input int a, input int b);
      n_tests++;
      if (a != b) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", n, a, b);
      end
   endtask
   function automatic vec_t mk(input int hfp, hsy, hbp, hact, vfp, vsy, vbp, vact,
                               input logic hp, vp, err, pend,
                               input int fr, lines, den, fde, hoff, hw, vsn, input logic ehp, evp);
      vec_t v;
      v.hfp = hfp; v.hsy = hsy; v.hbp = hbp; v.hact = hact;
      v.vfp = vfp; v.vsy = vsy; v.vbp = vbp; v.vact = vact;
      v.hp = hp; v.vp = vp; v.err = err; v.pend = pend;
      v.e.fr = fr; v.e.lines = lines; v.e.de_n = den; v.e.first_de = fde;
      v.e.hs_off = hoff; v.e.hs_w = hw; v.e.vs_n = vsn; v.e.hp = ehp; v.e.vp = evp;
      return v;
   endfunction
   // drive at a negedge; returns at the next negedge with the load already sampled
   task automatic load(input vec_t v);
      cfg_h_fp = CW'(v.hfp); cfg_h_sync = CW'(v.hsy); cfg_h_bp = CW'(v.hbp); cfg_h_active = CW'(v.hact);
      cfg_v_fp = CW'(v.vfp); cfg_v_sync = CW'(v.vsy); cfg_v_bp = CW'(v.vbp); cfg_v_active = CW'(v.vact);
      cfg_hs_pol = v.hp; cfg_vs_pol = v.vp; cfg_load = 1'b1;
      @(negedge dp_clk);
      cfg_load = 1'b0;
   endtask
   task automatic wait_fs(output int w);
      w = 0;
      do begin
         @(negedge dp_clk);
         w++;
      end while (!frame_start && w < 20000);
      if (!frame_start) begin
         n_tests++;
         n_fail++;
         $display("FAIL fs_wait: no frame_start within %0d cycles, required one", w);
      end
   endtask
   // starts on a sample showing frame_start; ends on the next frame_start sample
   task automatic measure(input exp_t e);
      int t = 0, ln = 0, den = 0, fde = -1, hoff = -1, hw = 0, vsn = 0;
      int bad = 0, xi = 0, yi = 0;
      logic had = 1'b0;
      do begin
         if (line_start) begin
            ln++;
            if (had) yi++;
            xi = 0;
            had = 1'b0;
         end
         if (de) begin
            den++;
            if (fde < 0) fde = t;
`ifdef VTG_COORD_EN
            if (int'(x_pos) != xi || int'(y_pos) != yi) bad++;
`endif
            xi++;
            had = 1'b1;
         end
`ifdef VTG_COORD_EN
         else if (x_pos != '0 || y_pos != '0) bad++;
`endif
         if (hs == e.hp) begin
            if (hoff < 0) hoff = t;
            if (ln == 1) hw++;
         end
         if (vs == e.vp) vsn++;
         @(negedge dp_clk);
         t++;
      end while (!frame_start && t < 20000);
      chk("frame_len", t, e.fr);
      chk("lines", ln, e.lines);
      chk("de_count", den, e.de_n);
      chk("first_de", fde, e.first_de);
      chk("hs_offset", hoff, e.hs_off);
      chk("hs_width", hw, e.hs_w);
      chk("vs_cycles", vsn, e.vs_n);
      chk("coord_errors", bad, 0);
   endtask
   task automatic sb_check();
      if (sb.size() == 0) chk("sb_empty", 0, 1);
      else measure(sb.pop_front());
   endtask
   initial begin
      int w, act;
      tab[0] = mk(2,3,4,8,       1,2,1,4, 0,0, 0,0, 136,8,32,77,2,3,34, 0,0);
      tab[1] = mk(1,1,1,1,       1,1,1,1, 1,1, 0,1, 16,4,1,15,1,1,4, 1,1);
      tab[2] = mk(1,1,1,0,       1,1,1,1, 0,0, 1,0, 16,4,1,15,1,1,4, 1,1);
      tab[3] = mk(0,5,0,10,      0,1,0,3, 1,0, 0,1, 60,4,30,20,0,5,15, 1,0);
      tab[4] = mk(100,100,100,3900, 1,1,1,1, 0,0, 1,0, 60,4,30,20,0,5,15, 1,0);
      tab[5] = mk(1,1,1,1,       1,0,1,1, 0,0, 1,0, 60,4,30,20,0,5,15, 1,0);
      tab[6] = mk(1,1,1,4092,    0,1,0,1, 0,1, 0,1, 8190,2,4092,4098,1,1,4095, 0,1);
      tab[7] = mk(1,1,1,4093,    0,1,0,1, 1,1, 1,0, 8190,2,4092,4098,1,1,4095, 0,1);
      tab[8] = mk(1,1,1,1,       1,1,1,1, 1,1, 0,1, 16,4,1,15,1,1,4, 1,1);
      repeat (3) @(negedge dp_clk);
      chk("rst_hs", hs, 0); chk("rst_vs", vs, 0); chk("rst_de", de, 0);
      chk("rst_fs", frame_start, 0); chk("rst_ls", line_start, 0);
      chk("rst_pend", cfg_pending, 0); chk("rst_err", cfg_err, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge dp_clk);
      chk("idle_de", de, 0); chk("idle_fs", frame_start, 0); chk("idle_ls", line_start, 0);
      chk("idle_hs", hs, 1); chk("idle_vs", vs, 1);
      for (int i = 0; i < 9; i++) begin
         load(tab[i]);
         if (!tab[i].err) sb.push_back(tab[i].e);
         chk($sformatf("err_%0d", i), cfg_err, tab[i].err);
         chk($sformatf("pend_%0d", i), cfg_pending, tab[i].pend);
         if (tab[i].err) begin
            sb.push_back(tab[i].e);
            @(negedge dp_clk);
            chk($sformatf("err_pulse_%0d", i), cfg_err, 0);
         end
         if (i == 0) begin
            chk("idle_hs_loaded", hs, 1); chk("idle_de_loaded", de, 0);
            run = 1'b1;
            @(negedge dp_clk);
            chk("start_fs", frame_start, 1); chk("start_ls", line_start, 1);
         end else wait_fs(w);
         chk($sformatf("pend_clear_%0d", i), cfg_pending, 0);
         sb_check();
      end
      // load landing on the apply cycle replaces the pending one and takes effect at once
      load(tab[3]);
      chk("coinc_pend_set", cfg_pending, 1);
      repeat (13) @(negedge dp_clk);
      load(tab[0]);
      sb.push_back(tab[0].e);
      chk("coinc_pend_clr", cfg_pending, 0);
      wait_fs(w);
      chk("coinc_fs_wait", w, 1);
      sb_check();
      // run dropped inside active video
      repeat (80) @(negedge dp_clk);
      chk("stop_de_before", de, 1);
      run = 1'b0;
      repeat (2) @(negedge dp_clk);
      chk("stop_de", de, 0); chk("stop_hs", hs, 1); chk("stop_vs", vs, 1);
      chk("stop_fs", frame_start, 0); chk("stop_ls", line_start, 0);
      run = 1'b1;
      sb.push_back(tab[0].e);
      @(negedge dp_clk);
      chk("restart_fs", frame_start, 1); chk("restart_ls", line_start, 1);
      sb_check();
      // asynchronous reset during active video
      w = 0;
      while (!de && w < 500) begin
         @(negedge dp_clk);
         w++;
      end
      chk("pre_rst_de", de, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hs", hs, 0); chk("arst_vs", vs, 0); chk("arst_de", de, 0);
      chk("arst_fs", frame_start, 0); chk("arst_ls", line_start, 0);
      chk("arst_pend", cfg_pending, 0); chk("arst_err", cfg_err, 0);
      @(negedge dp_clk);
      rst_n = 1'b1;
      act = 0;
      repeat (300) begin
         @(negedge dp_clk);
         if (de || frame_start || line_start) act++;
      end
      chk("post_rst_activity", act, 0);
      load(tab[1]);
      sb.push_back(tab[1].e);
      chk("post_rst_err", cfg_err, 0);
      chk("post_rst_pend", cfg_pending, 0);
      wait_fs(w);
      chk("post_rst_fs_wait", w, 1);
      sb_check();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
